wb_arbiter_ctrl: RTL and testbench

Write-back controller that shares the single register-file write port between two requesters: the ALU result path and the data-memory load-return path. It arbitrates round-robin when both are valid and registers the winning write. It drives the write-back mux select (1 = ALU, 0 = memory) and tracks outstanding loads so issue logic can stall before the return path overflows.

---
 rtl/wb_arbiter_ctrl_pkg.sv | 22 ++
 rtl/wb_arbiter_ctrl_if.sv | 52 +++++
 rtl/wb_arbiter_ctrl_rr_arbiter.sv | 53 +++++
 rtl/wb_arbiter_ctrl.sv | 107 ++++++++++
 tb/tb_wb_arbiter_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_ctrl_pkg.sv
// Shared types and constants for the write-back controller:
// grant encoding, mux-select values and default widths.
package wb_arbiter_ctrl_pkg;

   localparam int unsigned XLEN_DEF      = 32;
   localparam int unsigned RADDR_DEF     = 5;
   localparam int unsigned MAX_LOADS_DEF = 4;

   localparam logic WB_SEL_ALU = 1'b1;
   localparam logic WB_SEL_MEM = 1'b0;

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_MEM = 1'b1
   } grant_e;

   // Width needed to hold a count from 0 to n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/wb_arbiter_ctrl_if.sv
// Bundle of the ALU/memory write-back handshakes, load tracking and
// register-file write port; slave = controller side, master = environment.
interface wb_arbiter_ctrl_if
   import wb_arbiter_ctrl_pkg::*;
#(
   parameter int unsigned XLEN      = XLEN_DEF,
   parameter int unsigned RADDR     = RADDR_DEF,
   parameter int unsigned MAX_LOADS = MAX_LOADS_DEF
);
   localparam int unsigned CW = cnt_width(MAX_LOADS);

   logic             alu_valid;
   logic [RADDR-1:0] alu_rd;
   logic [XLEN-1:0]  alu_data;
   logic             alu_ready;

   logic             mem_valid;
   logic [RADDR-1:0] mem_rd;
   logic [XLEN-1:0]  mem_data;
   logic             mem_ready;

   logic             ld_issue;
   logic             ld_full;
   logic [CW-1:0]    ld_count;
   logic             ovf_err;

   logic             rf_we;
   logic [RADDR-1:0] rf_waddr;
   logic [XLEN-1:0]  rf_wdata;
   logic             wb_sel;

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  mem_valid, mem_rd, mem_data,
      output mem_ready,
      input  ld_issue,
      output ld_full, ld_count, ovf_err,
      output rf_we, rf_waddr, rf_wdata, wb_sel
   );

   modport master (
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output mem_valid, mem_rd, mem_data,
      input  mem_ready,
      output ld_issue,
      input  ld_full, ld_count, ovf_err,
      input  rf_we, rf_waddr, rf_wdata, wb_sel
   );

endinterface

// File: rtl/wb_arbiter_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter between the ALU and memory return paths;
// remembers the last granted side so contention alternates.
module wb_rr_arbiter
   import wb_arbiter_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   alu_valid,
   input  logic   mem_valid,
   output logic   alu_ready,
   output logic   mem_ready,
   output grant_e grant,
   output logic   grant_valid
);

   grant_e last_grant;
   grant_e last_grant_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= GNT_MEM;
      end else begin
         last_grant <= last_grant_nxt;
      end
   end

   // Ready only ever follows its own valid, so a grant is always a transfer.
   always_comb begin
      last_grant_nxt = last_grant;
      alu_ready      = 1'b0;
      mem_ready      = 1'b0;
      grant          = GNT_ALU;
      grant_valid    = 1'b0;

      if (alu_valid && mem_valid) begin
         grant       = (last_grant == GNT_ALU) ? GNT_MEM : GNT_ALU;
         grant_valid = 1'b1;
      end else if (alu_valid) begin
         grant       = GNT_ALU;
         grant_valid = 1'b1;
      end else if (mem_valid) begin
         grant       = GNT_MEM;
         grant_valid = 1'b1;
      end

      if (grant_valid) begin
         alu_ready      = (grant == GNT_ALU);
         mem_ready      = (grant == GNT_MEM);
         last_grant_nxt = grant;
      end
   end

endmodule

// File: rtl/wb_arbiter_ctrl.sv
// Write-back controller: arbitrates ALU results and load returns onto the
// single register-file write port and tracks outstanding loads.
module wb_arbiter_ctrl
   import wb_arbiter_ctrl_pkg::*;
#(
   parameter int unsigned XLEN      = XLEN_DEF,
   parameter int unsigned RADDR     = RADDR_DEF,
   parameter int unsigned MAX_LOADS = MAX_LOADS_DEF
) (
   input logic              clk,
   input logic              rst,
   wb_arbiter_ctrl_if.slave bus
);

   localparam int unsigned CW = cnt_width(MAX_LOADS);

   logic             alu_ready;
   logic             mem_ready;
   grant_e           grant;
   logic             grant_valid;

   logic [RADDR-1:0] win_rd;
   logic [XLEN-1:0]  win_data;
   logic             win_sel;
   logic             mem_xfer;
   logic             issue_ok;
   logic             ret_dec;
   logic             ovf_set;

   logic [CW-1:0]    ld_count_q;
   logic             ld_full;
   logic             ovf_err_q;
   logic             rf_we_q;
   logic [RADDR-1:0] rf_waddr_q;
   logic [XLEN-1:0]  rf_wdata_q;
   logic             wb_sel_q;

   wb_rr_arbiter u_arb (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (bus.alu_valid),
      .mem_valid   (bus.mem_valid),
      .alu_ready   (alu_ready),
      .mem_ready   (mem_ready),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Winning write payload and load-counter events for this cycle.
   always_comb begin
      win_rd   = bus.alu_rd;
      win_data = bus.alu_data;
      win_sel  = WB_SEL_ALU;
      if (grant == GNT_MEM) begin
         win_rd   = bus.mem_rd;
         win_data = bus.mem_data;
         win_sel  = WB_SEL_MEM;
      end
      mem_xfer = bus.mem_valid && mem_ready;
      issue_ok = bus.ld_issue && !ld_full;
      ret_dec  = mem_xfer && (ld_count_q != '0);
      ovf_set  = (bus.ld_issue && ld_full) || (mem_xfer && (ld_count_q == '0));
   end

   assign ld_full = (ld_count_q == CW'(MAX_LOADS));

   // Outstanding-load count and sticky overflow/underflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_count_q <= '0;
         ovf_err_q  <= 1'b0;
      end else begin
         ld_count_q <= ld_count_q + CW'(issue_ok) - CW'(ret_dec);
         if (ovf_set) begin
            ovf_err_q <= 1'b1;
         end
      end
   end

   // Registered write port; writes to x0 are consumed but never enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_sel_q   <= WB_SEL_ALU;
      end else begin
         rf_we_q <= grant_valid && (win_rd != '0);
         if (grant_valid) begin
            rf_waddr_q <= win_rd;
            rf_wdata_q <= win_data;
            wb_sel_q   <= win_sel;
         end
      end
   end

   assign bus.alu_ready = alu_ready;
   assign bus.mem_ready = mem_ready;
   assign bus.ld_full   = ld_full;
   assign bus.ld_count  = ld_count_q;
   assign bus.ovf_err   = ovf_err_q;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.wb_sel    = wb_sel_q;

endmodule

// File: tb/tb_wb_arbiter_ctrl.sv
// Directed scoreboard bench for wb_arbiter_ctrl: vectors push expected
// readies and next-cycle outputs; a negedge monitor pops and compares.
module tb_wb_arbiter_ctrl;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        sel;
      logic [2:0]  cnt;
      logic        full;
      logic        ovf;
   } out_t;

   typedef struct {
      logic ar;
      logic mr;
   } rdy_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_cmp = 0;
   int n_err = 0;

   rdy_t rq[$];
   out_t oq[$];
   out_t cur;
   logic cur_valid = 1'b0;

   wb_arbiter_ctrl_if #(.XLEN(32), .RADDR(5), .MAX_LOADS(4)) bus ();

   wb_arbiter_ctrl #(.XLEN(32), .RADDR(5), .MAX_LOADS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int av, input int ard, input int adat,
                        input int mv, input int mrd, input int mdat, input int iss);
      bus.alu_valid = 1'(av);
      bus.alu_rd    = 5'(ard);
      bus.alu_data  = 32'(adat);
      bus.mem_valid = 1'(mv);
      bus.mem_rd    = 5'(mrd);
      bus.mem_data  = 32'(mdat);
      bus.ld_issue  = 1'(iss);
   endtask

   // One vector per cycle: inputs, same-cycle readies, next-cycle outputs.
   task automatic vec(input int av, input int ard, input int adat,
                      input int mv, input int mrd, input int mdat, input int iss,
                      input int ar, input int mr,
                      input int we, input int wa, input int wd, input int sel,
                      input int cnt, input int full, input int ovf);
      rdy_t r;
      out_t o;
      @(posedge clk);
      #1;
      drive(av, ard, adat, mv, mrd, mdat, iss);
      r.ar   = 1'(ar);
      r.mr   = 1'(mr);
      o.we   = 1'(we);
      o.wa   = 5'(wa);
      o.wd   = 32'(wd);
      o.sel  = 1'(sel);
      o.cnt  = 3'(cnt);
      o.full = 1'(full);
      o.ovf  = 1'(ovf);
      rq.push_back(r);
      oq.push_back(o);
      n_vec++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         drive(0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   always @(negedge clk) begin
      if (cur_valid) begin
         chk("rf_we",    32'(bus.rf_we),    32'(cur.we));
         chk("rf_waddr", 32'(bus.rf_waddr), 32'(cur.wa));
         chk("rf_wdata", bus.rf_wdata,      cur.wd);
         chk("wb_sel",   32'(bus.wb_sel),   32'(cur.sel));
         chk("ld_count", 32'(bus.ld_count), 32'(cur.cnt));
         chk("ld_full",  32'(bus.ld_full),  32'(cur.full));
         chk("ovf_err",  32'(bus.ovf_err),  32'(cur.ovf));
         cur_valid = 1'b0;
      end
      if (rq.size() > 0 && oq.size() > 0) begin
         rdy_t r;
         r = rq.pop_front();
         chk("alu_ready", 32'(bus.alu_ready), 32'(r.ar));
         chk("mem_ready", 32'(bus.mem_ready), 32'(r.mr));
         cur       = oq.pop_front();
         cur_valid = 1'b1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rf_we",    32'(bus.rf_we),    32'd0);
      chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("rst_rf_wdata", bus.rf_wdata,      32'd0);
      chk("rst_wb_sel",   32'(bus.wb_sel),   32'd1);
      chk("rst_ld_count", 32'(bus.ld_count), 32'd0);
      chk("rst_ld_full",  32'(bus.ld_full),  32'd0);
      chk("rst_ovf_err",  32'(bus.ovf_err),  32'd0);
      rst = 1'b0;

      //  av rd  adat    mv rd  mdat    iss  ar mr  we wa wd       sel cnt fu ov
      vec(1, 5,  'h1234, 0, 0,  0,      1,   1, 0,  1, 5, 'h1234,  1,  1,  0, 0);
      vec(1, 0,  'hFFFF, 0, 0,  0,      1,   1, 0,  0, 0, 'hFFFF,  1,  2,  0, 0);
      vec(0, 0,  0,      0, 0,  0,      1,   0, 0,  0, 0, 'hFFFF,  1,  3,  0, 0);
      vec(0, 0,  0,      1, 6,  'h66,   0,   0, 1,  1, 6, 'h66,    0,  2,  0, 0);
      // Contention with last grant = MEM: ALU, MEM, ALU, MEM
      vec(1, 3,  'hAAAA, 1, 4,  'h5555, 0,   1, 0,  1, 3, 'hAAAA,  1,  2,  0, 0);
      vec(1, 3,  'hAAAA, 1, 4,  'h5555, 0,   0, 1,  1, 4, 'h5555,  0,  1,  0, 0);
      vec(1, 3,  'hAAAA, 1, 4,  'h5555, 0,   1, 0,  1, 3, 'hAAAA,  1,  1,  0, 0);
      vec(1, 3,  'hAAAA, 1, 4,  'h5555, 0,   0, 1,  1, 4, 'h5555,  0,  0,  0, 0);
      // Fill to MAX_LOADS, overflow, drain one, issue+return at 3
      vec(0, 0,  0,      0, 0,  0,      1,   0, 0,  0, 4, 'h5555,  0,  1,  0, 0);
      vec(0, 0,  0,      0, 0,  0,      1,   0, 0,  0, 4, 'h5555,  0,  2,  0, 0);
      vec(0, 0,  0,      0, 0,  0,      1,   0, 0,  0, 4, 'h5555,  0,  3,  0, 0);
      vec(0, 0,  0,      0, 0,  0,      1,   0, 0,  0, 4, 'h5555,  0,  4,  1, 0);
      vec(0, 0,  0,      0, 0,  0,      1,   0, 0,  0, 4, 'h5555,  0,  4,  1, 1);
      vec(0, 0,  0,      1, 7,  'h77,   0,   0, 1,  1, 7, 'h77,    0,  3,  0, 1);
      vec(0, 0,  0,      1, 8,  'h88,   1,   0, 1,  1, 8, 'h88,    0,  3,  0, 1);
      idle_cycles(2);

      // Asynchronous reset while a write sits in the output register
      @(posedge clk);
      #1;
      drive(1, 9, 'h99, 0, 0, 0, 0);
      n_vec++;
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_rf_we",    32'(bus.rf_we),    32'd1);
      chk("pre_rst_rf_waddr", 32'(bus.rf_waddr), 32'd9);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_rf_we",    32'(bus.rf_we),    32'd0);
      chk("async_rst_ld_count", 32'(bus.ld_count), 32'd0);
      chk("async_rst_ovf_err",  32'(bus.ovf_err),  32'd0);
      chk("async_rst_wb_sel",   32'(bus.wb_sel),   32'd1);
      #3;
      rst = 1'b0;

      //  av rd  adat    mv rd  mdat    iss  ar mr  we wa  wd      sel cnt fu ov
      vec(1, 10, 'hA0,   1, 11, 'hB0,   0,   1, 0,  1, 10, 'hA0,   1,  0,  0, 0);
      vec(0, 0,  0,      1, 12, 'hC0,   0,   0, 1,  1, 12, 'hC0,   0,  0,  0, 1);
      vec(0, 0,  0,      0, 0,  0,      0,   0, 0,  0, 12, 'hC0,   0,  0,  0, 1);
      idle_cycles(3);

      chk("scoreboard_drained", 32'(rq.size() + oq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
